// File: rtl/clock_group_seq.sv
// Clock-group member sequencer: POR stretch, drain-before-gate with timeout, clock-first/reset-last wake.
// Latency: every output is registered and reflects the input sampled at the previous clock edge.
// Backpressure: none; run_req is a level and run_ack follows it. CLOCK_GROUP_SEQ_STATS_EN enables gate_count.
module clock_group_seq #(
    parameter int RESET_CYCLES  = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int DRAIN_TIMEOUT = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run_req,
    input  logic        domain_idle,
    output logic        run_ack,
    output logic        out_clk_en,
    output logic        out_reset,
    output logic        timeout_err,
    output logic [2:0]  state_o,
    output logic [15:0] gate_count
);

    localparam int MAX_A   = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int MAX_CYC = (MAX_A > DRAIN_TIMEOUT) ? MAX_A : DRAIN_TIMEOUT;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] RST_LOAD    = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LOAD  = CW'(DRAIN_TIMEOUT - 1);
    localparam logic [CW-1:0] POR_LOAD    = CW'((RESET_CYCLES > 1) ? RESET_CYCLES - 2 : 0);

    typedef enum logic [2:0] {
        ST_POR        = 3'd0,
        ST_RUN        = 3'd1,
        ST_DRAIN      = 3'd2,
        ST_ASSERT_RST = 3'd3,
        ST_GATED      = 3'd4,
        ST_WAKE       = 3'd5
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          por_armed;

    // {clk_en, reset, ack} for each state, registered alongside the state itself
    function automatic logic [2:0] outs(input state_t s);
        case (s)
            ST_RUN:   return 3'b101;
            ST_DRAIN: return 3'b100;
            ST_GATED: return 3'b010;
            default:  return 3'b110;
        endcase
    endfunction

    assign state_o = state;

    // The first POR cycle after reset is spent loading the counter, so the stretch still lasts RESET_CYCLES.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                              <= ST_POR;
            cnt                                <= '0;
            por_armed                          <= 1'b0;
            {out_clk_en, out_reset, run_ack}   <= 3'b110;
            timeout_err                        <= 1'b0;
`ifdef CLOCK_GROUP_SEQ_STATS_EN
            gate_count                         <= 16'h0000;
`endif
        end else begin
            case (state)
                ST_POR: begin
                    if (!por_armed && RESET_CYCLES > 1) begin
                        por_armed <= 1'b1;
                        cnt       <= POR_LOAD;
                    end else if (!por_armed || cnt == '0) begin
                        por_armed <= 1'b1;
                        cnt       <= '0;
                        if (run_req) begin
                            state                            <= ST_RUN;
                            {out_clk_en, out_reset, run_ack} <= outs(ST_RUN);
                        end else begin
                            state                            <= ST_GATED;
                            {out_clk_en, out_reset, run_ack} <= outs(ST_GATED);
`ifdef CLOCK_GROUP_SEQ_STATS_EN
                            if (gate_count != 16'hFFFF) gate_count <= gate_count + 16'd1;
`endif
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!run_req) begin
                        state                            <= ST_DRAIN;
                        cnt                              <= DRAIN_LOAD;
                        {out_clk_en, out_reset, run_ack} <= outs(ST_DRAIN);
                    end
                end
                ST_DRAIN: begin
                    if (run_req) begin
                        state                            <= ST_RUN;
                        cnt                              <= '0;
                        {out_clk_en, out_reset, run_ack} <= outs(ST_RUN);
                    end else if (domain_idle || cnt == '0) begin
                        state                            <= ST_ASSERT_RST;
                        cnt                              <= SETTLE_LOAD;
                        {out_clk_en, out_reset, run_ack} <= outs(ST_ASSERT_RST);
                        if (!domain_idle) timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ASSERT_RST: begin
                    if (cnt == '0) begin
                        state                            <= ST_GATED;
                        {out_clk_en, out_reset, run_ack} <= outs(ST_GATED);
`ifdef CLOCK_GROUP_SEQ_STATS_EN
                        if (gate_count != 16'hFFFF) gate_count <= gate_count + 16'd1;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_GATED: begin
                    if (run_req) begin
                        state                            <= ST_WAKE;
                        cnt                              <= RST_LOAD;
                        {out_clk_en, out_reset, run_ack} <= outs(ST_WAKE);
                    end
                end
                ST_WAKE: begin
                    if (cnt == '0) begin
                        state                            <= ST_RUN;
                        {out_clk_en, out_reset, run_ack} <= outs(ST_RUN);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state                            <= ST_POR;
                    cnt                              <= '0;
                    por_armed                        <= 1'b0;
                    {out_clk_en, out_reset, run_ack} <= 3'b110;
                end
            endcase
        end
    end

`ifndef CLOCK_GROUP_SEQ_STATS_EN
    assign gate_count = 16'h0000;
`endif

    ap_gate_in_reset: assert property (@(posedge clock) disable iff (!reset)
        $fell(out_clk_en) |-> $past(out_reset));
    ap_clock_before_release: assert property (@(posedge clock) disable iff (!reset)
        $rose(out_clk_en) |-> !$fell(out_reset));
    ap_ack_consistent: assert property (@(posedge clock) disable iff (!reset)
        run_ack |-> (out_clk_en && !out_reset));

endmodule

// File: tb/tb_clock_group_seq.sv
// Directed bench for clock_group_seq with DRAIN_TIMEOUT=16; gate_count expectations follow CLOCK_GROUP_SEQ_STATS_EN.
module tb_clock_group_seq;

`ifdef CLOCK_GROUP_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // {state, clk_en, reset, ack}
    localparam logic [5:0] E_POR    = {3'd0, 3'b110};
    localparam logic [5:0] E_RUN    = {3'd1, 3'b101};
    localparam logic [5:0] E_DRAIN  = {3'd2, 3'b100};
    localparam logic [5:0] E_ASSERT = {3'd3, 3'b110};
    localparam logic [5:0] E_GATED  = {3'd4, 3'b010};
    localparam logic [5:0] E_WAKE   = {3'd5, 3'b110};

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_req = 1'b1;
    logic        domain_idle = 1'b1;
    logic        run_ack, out_clk_en, out_reset, timeout_err;
    logic [2:0]  state_o;
    logic [15:0] gate_count;
    logic [5:0]  obs;

    int n_cmp = 0;
    int n_err = 0;

    clock_group_seq #(.RESET_CYCLES(8), .SETTLE_CYCLES(4), .DRAIN_TIMEOUT(16)) dut (
        .clock       (clock),
        .reset       (rst_n),
        .run_req     (run_req),
        .domain_idle (domain_idle),
        .run_ack     (run_ack),
        .out_clk_en  (out_clk_en),
        .out_reset   (out_reset),
        .timeout_err (timeout_err),
        .state_o     (state_o),
        .gate_count  (gate_count)
    );

    always #5 clock = ~clock;

    assign obs = {state_o, out_clk_en, out_reset, run_ack};

    function automatic logic [15:0] exp_gc(input int n);
        return STATS ? 16'(n) : 16'h0000;
    endfunction

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        run_req = 1'b1; domain_idle = 1'b1;
        tick();
        n_cmp++;
        if (obs !== E_POR || timeout_err !== 1'b0 || gate_count !== 16'h0) begin
            n_err++;
            $display("FAIL reset_state obs=%b terr=%b gc=%h want obs=%b terr=0 gc=0", obs, timeout_err, gate_count, E_POR);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_cmp++;
            if (obs !== E_POR) begin
                n_err++;
                $display("FAIL por_stretch cyc=%0d obs=%b want %b", i, obs, E_POR);
            end
        end
        tick();
        n_cmp++;
        if (obs !== E_RUN) begin
            n_err++;
            $display("FAIL por_to_run obs=%b want %b", obs, E_RUN);
        end
    endtask

    task automatic test_drain_idle();
        run_req = 1'b0; domain_idle = 1'b1;
        tick();
        n_cmp++;
        if (obs !== E_DRAIN) begin
            n_err++;
            $display("FAIL drain_enter obs=%b want %b", obs, E_DRAIN);
        end
        tick();
        n_cmp++;
        if (obs !== E_ASSERT) begin
            n_err++;
            $display("FAIL drain_one_cycle obs=%b want %b", obs, E_ASSERT);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if (obs !== E_ASSERT) begin
                n_err++;
                $display("FAIL settle cyc=%0d obs=%b want %b", i, obs, E_ASSERT);
            end
        end
        tick();
        n_cmp++;
        if (obs !== E_GATED || gate_count !== exp_gc(1)) begin
            n_err++;
            $display("FAIL gated_idle obs=%b gc=%h want obs=%b gc=%h", obs, gate_count, E_GATED, exp_gc(1));
        end
    endtask

    task automatic test_wake_pulse();
        run_req = 1'b1;
        tick();
        n_cmp++;
        if (obs !== E_WAKE) begin
            n_err++;
            $display("FAIL wake_clock_first obs=%b want %b", obs, E_WAKE);
        end
        tick();
        run_req = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            n_cmp++;
            if (obs !== E_WAKE) begin
                n_err++;
                $display("FAIL wake_hold cyc=%0d obs=%b want %b", i, obs, E_WAKE);
            end
            if (i < 8) tick();
        end
        tick();
        n_cmp++;
        if (obs !== E_RUN) begin
            n_err++;
            $display("FAIL wake_run_once obs=%b want %b", obs, E_RUN);
        end
        tick();
        n_cmp++;
        if (obs !== E_DRAIN) begin
            n_err++;
            $display("FAIL wake_then_drain obs=%b want %b", obs, E_DRAIN);
        end
        repeat (5) tick();
        n_cmp++;
        if (obs !== E_GATED || gate_count !== exp_gc(2)) begin
            n_err++;
            $display("FAIL wake_regate obs=%b gc=%h want obs=%b gc=%h", obs, gate_count, E_GATED, exp_gc(2));
        end
    endtask

    task automatic test_drain_abort();
        logic saw_reset;
        run_req = 1'b1;
        repeat (9) tick();
        n_cmp++;
        if (obs !== E_RUN) begin
            n_err++;
            $display("FAIL abort_setup obs=%b want %b", obs, E_RUN);
        end
        run_req = 1'b0; domain_idle = 1'b0;
        saw_reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (out_reset !== 1'b0) saw_reset = 1'b1;
        end
        n_cmp++;
        if (obs !== E_DRAIN) begin
            n_err++;
            $display("FAIL abort_in_drain obs=%b want %b", obs, E_DRAIN);
        end
        run_req = 1'b1;
        tick();
        if (out_reset !== 1'b0) saw_reset = 1'b1;
        n_cmp++;
        if (obs !== E_RUN || saw_reset !== 1'b0 || gate_count !== exp_gc(2)) begin
            n_err++;
            $display("FAIL abort_return obs=%b rst_pulse=%b gc=%h want obs=%b rst_pulse=0 gc=%h",
                     obs, saw_reset, gate_count, E_RUN, exp_gc(2));
        end
    endtask

    task automatic test_timeout();
        run_req = 1'b0; domain_idle = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_cmp++;
            if (obs !== E_DRAIN || timeout_err !== 1'b0) begin
                n_err++;
                $display("FAIL timeout_wait cyc=%0d obs=%b terr=%b want obs=%b terr=0", i, obs, timeout_err, E_DRAIN);
            end
        end
        tick();
        n_cmp++;
        if (obs !== E_ASSERT || timeout_err !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_fire obs=%b terr=%b want obs=%b terr=1", obs, timeout_err, E_ASSERT);
        end
        repeat (4) tick();
        n_cmp++;
        if (obs !== E_GATED || gate_count !== exp_gc(3)) begin
            n_err++;
            $display("FAIL timeout_gated obs=%b gc=%h want obs=%b gc=%h", obs, gate_count, E_GATED, exp_gc(3));
        end
        run_req = 1'b1;
        repeat (9) tick();
        n_cmp++;
        if (obs !== E_RUN || timeout_err !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_sticky obs=%b terr=%b want obs=%b terr=1", obs, timeout_err, E_RUN);
        end
    endtask

    task automatic test_reset_mid_assert();
        run_req = 1'b0; domain_idle = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (obs !== E_ASSERT) begin
            n_err++;
            $display("FAIL mid_assert_setup obs=%b want %b", obs, E_ASSERT);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== E_POR || gate_count !== 16'h0 || timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_assert obs=%b gc=%h terr=%b want obs=%b gc=0 terr=0", obs, gate_count, timeout_err, E_POR);
        end
        run_req = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        n_cmp++;
        if (obs !== E_RUN) begin
            n_err++;
            $display("FAIL rerun_after_reset obs=%b want %b", obs, E_RUN);
        end
    endtask

    task automatic test_idle_wins();
        run_req = 1'b0; domain_idle = 1'b0;
        repeat (16) tick();
        domain_idle = 1'b1;
        tick();
        n_cmp++;
        if (obs !== E_ASSERT || timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL idle_beats_timeout obs=%b terr=%b want obs=%b terr=0", obs, timeout_err, E_ASSERT);
        end
        repeat (4) tick();
        n_cmp++;
        if (obs !== E_GATED || gate_count !== exp_gc(1)) begin
            n_err++;
            $display("FAIL idle_wins_gated obs=%b gc=%h want obs=%b gc=%h", obs, gate_count, E_GATED, exp_gc(1));
        end
    endtask

    task automatic test_reset_mid_wake();
        run_req = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (obs !== E_WAKE) begin
            n_err++;
            $display("FAIL mid_wake_setup obs=%b want %b", obs, E_WAKE);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== E_POR || gate_count !== 16'h0 || timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_wake obs=%b gc=%h terr=%b want obs=%b gc=0 terr=0", obs, gate_count, timeout_err, E_POR);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_drain_idle();
        test_wake_pulse();
        test_drain_abort();
        test_timeout();
        test_reset_mid_assert();
        test_idle_wins();
        test_reset_mid_wake();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
